// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared FSM state type and width limits for the sequential divider
package div_pkg;

    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_dvsr,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_qbit
);

    // Shifted remainder minus divisor; the extra top bit is the borrow.
    // The running remainder is always below the divisor, so the shifted
    // value never overflows WIDTH+1 bits and the borrow bit is the sign.
    logic [WIDTH+1:0] w_diff;

    assign w_diff = {i_rem, i_bit} - {2'b00, i_dvsr};

    // Keep the difference when it is non-negative, otherwise restore
    always_comb begin
        o_qbit = ~w_diff[WIDTH+1];
        o_rem  = o_qbit ? w_diff[WIDTH:0] : {i_rem[WIDTH-1:0], i_bit};
    end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - fixed-latency restoring divider, signed or unsigned
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t r_state;
    state_t w_next_state;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvsr;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;
    logic             r_done;

    logic             w_signed;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_qbit;

    // Operand conditioning: magnitudes and signs taken at capture time.
    // Negating the most-negative value yields itself, which read as
    // unsigned is the correct magnitude.
    assign w_signed  = SIGNED_EN && signed_mode;
    assign w_dvd_neg = w_signed & dividend[WIDTH-1];
    assign w_dvs_neg = w_signed & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? (~dividend + 1'b1) : dividend;
    assign w_dvs_mag = w_dvs_neg ? (~divisor + 1'b1) : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem  (r_rem),
        .i_dvsr (r_dvsr),
        .i_bit  (r_quo[WIDTH-1]),
        .o_rem  (w_step_rem),
        .o_qbit (w_step_qbit)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: CALC runs WIDTH cycles, FIN is a single cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (start) w_next_state = CALC;
            CALC: if (r_cnt == CNT_W'(1)) w_next_state = FIN;
            FIN:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Datapath: capture operands, iterate, then sign-correct and publish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= '0;
            r_rem         <= '0;
            r_quo         <= '0;
            r_dvsr        <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dbz         <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_done <= (r_state == FIN);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_cnt   <= CNT_W'(WIDTH);
                        r_rem   <= '0;
                        r_quo   <= w_dvd_mag;
                        r_dvsr  <= w_dvs_mag;
                        r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg <= w_dvd_neg;
                        r_dbz   <= (divisor == '0);
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 1'b1;
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_qbit};
                end
                FIN: begin
                    // A zero divisor leaves the dividend magnitude in the
                    // remainder, so sign correction restores the original
                    // dividend; only the quotient needs forcing.
                    if (r_dbz) begin
                        r_quotient <= '1;
                    end else begin
                        r_quotient <= r_q_neg ? (~r_quo + 1'b1) : r_quo;
                    end
                    r_remainder   <= r_r_neg ? (~r_rem[WIDTH-1:0] + 1'b1)
                                             : r_rem[WIDTH-1:0];
                    r_div_by_zero <= r_dbz;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE) || r_done;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule
